// File: rtl/neuron_config_loader.sv
// neuron_config_loader: takes 32-bit words from a host valid/ready stream
// and writes them to one layer's neuron array. Each neuron gets
// num_weights weight writes followed by one bias write.
//
// Optional feature (macro CFG_CHECKSUM_EN): a running 32-bit sum of every
// accepted word, cleared on each accepted start. When the macro is not
// defined, checksum is tied to 0 and no adder is built.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               1-cycle job request, sampled only in IDLE
//   cfg_layer           layer number for the job, latched on start
//   cfg_num_neurons     neurons in the layer, latched on start
//   cfg_num_weights     weights per neuron, latched on start
//   s_valid/s_data      host word stream
//   s_ready             loader accepts a word this cycle (decoded from state)
//   weightValid/Value   weight write strobe and word
//   biasValid/Value     bias write strobe and word
//   configLayerNum      target layer number
//   configNeuronNum     target neuron number, zero-extended
//   busy                job in progress
//   done                1-cycle pulse with the final bias write
//   err                 1-cycle pulse when a start is rejected
//   checksum            sum of accepted words (0 when feature disabled)
module neuron_config_loader #(
  parameter int unsigned NW_W = 16,
  parameter int unsigned NN_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     cfg_layer,
  input  logic [NN_W-1:0] cfg_num_neurons,
  input  logic [NW_W-1:0] cfg_num_weights,
  input  logic            s_valid,
  input  logic [31:0]     s_data,
  output logic            s_ready,
  output logic            weightValid,
  output logic [31:0]     weightValue,
  output logic            biasValid,
  output logic [31:0]     biasValue,
  output logic [31:0]     configLayerNum,
  output logic [31:0]     configNeuronNum,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [31:0]     checksum
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WEIGHT = 2'd1,
    BIAS   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_d;

  logic [NW_W-1:0]   num_w, num_w_d, wcnt, wcnt_d;
  logic [NN_W-1:0]   num_n, num_n_d, ncnt, ncnt_d;
  logic              weight_valid_d, bias_valid_d;
  logic [DATA_W-1:0] weight_value_d, bias_value_d;
  logic [DATA_W-1:0] layer_d, neuron_d;
  logic              busy_d, done_d, err_d;
  logic              accept, last_w, last_n;

  // Ready is a pure decode of state so the host sees it in the same cycle.
  assign s_ready = (state == WEIGHT) || (state == BIAS);
  assign accept  = s_valid && s_ready;

  // Full-width compare against count-1; counts are nonzero once latched.
  assign last_w = (wcnt == NW_W'(num_w - NW_W'(1)));
  assign last_n = (ncnt == NN_W'(num_n - NN_W'(1)));

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state;
    num_w_d        = num_w;
    num_n_d        = num_n;
    wcnt_d         = wcnt;
    ncnt_d         = ncnt;
    weight_valid_d = 1'b0;
    bias_valid_d   = 1'b0;
    weight_value_d = weightValue;
    bias_value_d   = biasValue;
    layer_d        = configLayerNum;
    neuron_d       = configNeuronNum;
    done_d         = 1'b0;
    err_d          = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if ((cfg_num_neurons != '0) && (cfg_num_weights != '0)) begin
            state_d = WEIGHT;
            num_w_d = cfg_num_weights;
            num_n_d = cfg_num_neurons;
            wcnt_d  = '0;
            ncnt_d  = '0;
            layer_d = cfg_layer;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WEIGHT: begin
        if (accept) begin
          weight_valid_d = 1'b1;
          weight_value_d = s_data;
          neuron_d       = DATA_W'(ncnt);
          if (last_w) begin
            wcnt_d  = '0;
            state_d = BIAS;
          end else begin
            wcnt_d = NW_W'(wcnt + NW_W'(1));
          end
        end
      end
      BIAS: begin
        if (accept) begin
          bias_valid_d = 1'b1;
          bias_value_d = s_data;
          neuron_d     = DATA_W'(ncnt);
          if (last_n) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            ncnt_d  = NN_W'(ncnt + NN_W'(1));
            state_d = WEIGHT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // DONE still counts as busy so busy drops the cycle after done.
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      num_w           <= '0;
      num_n           <= '0;
      wcnt            <= '0;
      ncnt            <= '0;
      weightValid     <= 1'b0;
      biasValid       <= 1'b0;
      weightValue     <= '0;
      biasValue       <= '0;
      configLayerNum  <= '0;
      configNeuronNum <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      state           <= state_d;
      num_w           <= num_w_d;
      num_n           <= num_n_d;
      wcnt            <= wcnt_d;
      ncnt            <= ncnt_d;
      weightValid     <= weight_valid_d;
      biasValid       <= bias_valid_d;
      weightValue     <= weight_value_d;
      biasValue       <= bias_value_d;
      configLayerNum  <= layer_d;
      configNeuronNum <= neuron_d;
      busy            <= busy_d;
      done            <= done_d;
      err             <= err_d;
    end
  end

`ifdef CFG_CHECKSUM_EN
  logic start_ok;

  assign start_ok = (state == IDLE) && start &&
                    (cfg_num_neurons != '0) && (cfg_num_weights != '0);

  // Running sum of accepted words; cleared when a job is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= DATA_W'(checksum + s_data);
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
